// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter sharing the store-buffer FIFO write port
//             among NUM_REQ requesters. It holds a registered write stage,
//             a mirror occupancy counter that blocks accepts into a full
//             FIFO, and a locked-burst mode that keeps one requester's
//             consecutive beats contiguous.
//  Ports    : clk, rst_n (async, active-low)
//             req_valid_i/req_data_i/req_lock_i -> requester side
//             req_ready_o                       <- one-hot grant (or zero)
//             fifo_wr_en_o/fifo_wr_data_o       -> FIFO write port
//             fifo_rd_en_i                      <- consumer read strobe
//             fifo_level_o, locked_o, underflow_o -> status
//  Option   : `define FIFO_ARB_STATS_EN adds per-requester accepted-beat
//             counters (stat_sel_i, stat_clr_i, stat_cnt_o).
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 2,
    parameter int MAX_BURST   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_lock_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    input  logic                          fifo_rd_en_i,
    output logic [DEPTH_WIDTH:0]          fifo_level_o,
    output logic                          locked_o,
    output logic                          underflow_o
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0]    stat_sel_i,
    input  logic                          stat_clr_i,
    output logic [15:0]                   stat_cnt_o
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int LW = DEPTH_WIDTH + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [LW:0]   c_depth      = (LW+1)'(2**DEPTH_WIDTH);
    localparam logic [BW-1:0] c_burst_last = BW'(MAX_BURST - 1);
    localparam bit            c_lock_en    = (MAX_BURST > 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  underflow_q, underflow_d;

    logic                  w_space;
    logic                  w_found;
    logic [IW-1:0]         w_gnt;
    logic                  w_acc;
    logic                  w_dec;

    // A write already in flight counts as occupied; a same-cycle read is
    // deliberately ignored so the mirror can never over-commit the FIFO.
    assign w_space = (({1'b0, level_q} + (LW+1)'(wr_en_q)) < c_depth);

    always_comb begin
        logic [IW-1:0] idx;
        w_found = 1'b0;
        w_gnt   = '0;
        idx     = '0;
        if (state_q == S_LOCKED) begin
            // Owner keeps the port even while it is momentarily not valid;
            // the FSM releases the lock on the next edge in that case.
            w_found = 1'b1;
            w_gnt   = owner_q;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!w_found && req_valid_i[idx]) begin
                    w_found = 1'b1;
                    w_gnt   = idx;
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (w_found) begin
            req_ready_o[w_gnt] = w_space;
        end
    end

    assign w_acc = w_found & req_valid_i[w_gnt] & w_space;
    assign w_dec = fifo_rd_en_i & (level_q != '0);

    always_comb begin
        wr_en_d     = w_acc;
        wr_data_d   = wr_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_acc) begin
            wr_data_d = req_data_i[w_gnt*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_d  = w_gnt;
        end

        level_d = level_q;
        if (wr_en_q && !w_dec) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en_q && w_dec) begin
            level_d = level_q - LW'(1);
        end

        underflow_d = underflow_q | (fifo_rd_en_i & (level_q == '0));
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_acc && req_lock_i[w_gnt] && c_lock_en) begin
                    state_d     = S_LOCKED;
                    owner_d     = w_gnt;
                    burst_cnt_d = BW'(1);
                end
            end
            S_LOCKED: begin
                if (!req_valid_i[owner_q]) begin
                    state_d     = S_IDLE;
                    burst_cnt_d = '0;
                end else if (w_acc) begin
                    // Forced release bounds how long others can be starved.
                    if (!req_lock_i[w_gnt] || (burst_cnt_q == c_burst_last)) begin
                        state_d     = S_IDLE;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_wr_data_o = wr_data_q;
    assign fifo_level_o   = level_q;
    assign locked_o       = (state_q == S_LOCKED);
    assign underflow_o    = underflow_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stat_cnt_q [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stat_cnt_q[r] <= '0;
            end else if (stat_clr_i) begin
                stat_cnt_q[r] <= '0;
            end else if (w_acc && (w_gnt == IW'(r)) && (stat_cnt_q[r] != 16'hFFFF)) begin
                stat_cnt_q[r] <= stat_cnt_q[r] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        if (int'(stat_sel_i) < NUM_REQ) begin
            stat_cnt_o = stat_cnt_q[stat_sel_i];
        end
    end
`endif

endmodule
`default_nettype wire
